// File: rtl/io_program_loader_if.sv
// io_program_loader_if
//   Groups the host nibble handshake, the load-mode control/status and the
//   word-write bus toward the memory controller.
//   master : the loader's view (drives ld_ack, mem_we, mem_addr, mem_wdata,
//            cpu_hold, done, err; receives enable, ld_req, ld_nibble, mem_busy)
//   slave  : the environment's view (host, mode pins and memory controller)
interface io_program_loader_if #(
    parameter int ADDR_W = 32
) ();
    logic              enable;
    logic              ld_req;
    logic [3:0]        ld_nibble;
    logic              ld_ack;
    logic              mem_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport master (
        input  enable, ld_req, ld_nibble, mem_busy,
        output ld_ack, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );

    modport slave (
        output enable, ld_req, ld_nibble, mem_busy,
        input  ld_ack, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/io_program_loader.sv
// io_program_loader
//   Streams a program image from the io pins into memory. The host sends a
//   header word (count[31:16], word address[15:0]), count payload words and
//   an XOR checksum word, each as 8 nibbles (LSB nibble first) over a 4-phase
//   ld_req/ld_ack handshake. Payload words are written to consecutive word
//   addresses through single-cycle mem_we strobes while cpu_hold keeps the
//   processor stalled.
//   Ports:
//     clk      system clock
//     reset_n  asynchronous active-low reset
//     bus      io_program_loader_if.master (handshake, memory bus, status)
module io_program_loader #(
    parameter int ADDR_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    io_program_loader_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        CSUM,
        DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic [31:0]            shift_reg;
    logic [31:0]            checksum;
    logic [2:0]             nib_cnt;
    logic [15:0]            word_cnt;
    logic                   receiving;
    logic                   accept;
    logic                   word_done;
    logic [31:0]            word;

    assign req_s     = req_sync[SYNC_STAGES-1];
    assign receiving = (state == HDR) || (state == DATA) || (state == CSUM);
    // enable is part of accept so an abort wins over a nibble in the same cycle
    assign accept    = req_s && !bus.ld_ack && receiving && bus.enable;
    // The word as it will look once the current nibble is shifted in
    assign word      = {bus.ld_nibble, shift_reg[31:4]};
    assign word_done = accept && (nib_cnt == 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            req_sync      <= '0;
            shift_reg     <= '0;
            checksum      <= '0;
            nib_cnt       <= '0;
            word_cnt      <= '0;
            bus.ld_ack    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_hold  <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], bus.ld_req};

            // With enable low every state heads to IDLE, so the next state is
            // busy exactly when enable is high: hold tracks enable one cycle late.
            bus.cpu_hold <= bus.enable;

            if (accept) begin
                shift_reg  <= word;
                nib_cnt    <= nib_cnt + 3'd1;
                bus.ld_ack <= 1'b1;
            end else if (!req_s && bus.ld_ack) begin
                bus.ld_ack <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        bus.done <= 1'b0;
                        bus.err  <= 1'b0;
                        checksum <= '0;
                        nib_cnt  <= '0;
                        state    <= HDR;
                    end
                end
                DONE: begin
                    if (!bus.enable) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (!bus.enable) begin
                        state      <= IDLE;
                        bus.err    <= 1'b1;
                        bus.mem_we <= 1'b0;
                    end else begin
                        case (state)
                            HDR: begin
                                if (word_done) begin
                                    word_cnt     <= word[31:16];
                                    bus.mem_addr <= ADDR_W'({word[15:0], 2'b00});
                                    state        <= (word[31:16] == 16'd0) ? CSUM : DATA;
                                end
                            end
                            DATA: begin
                                if (word_done) begin
                                    bus.mem_wdata <= word;
                                    checksum      <= checksum ^ word;
                                    state         <= WRITE;
                                end
                            end
                            WRITE: begin
                                // First pass raises the strobe, second pass retires it
                                if (bus.mem_we) begin
                                    bus.mem_we   <= 1'b0;
                                    bus.mem_addr <= bus.mem_addr + ADDR_W'(4);
                                    word_cnt     <= word_cnt - 16'd1;
                                    state        <= (word_cnt == 16'd1) ? CSUM : DATA;
                                end else if (!bus.mem_busy) begin
                                    bus.mem_we <= 1'b1;
                                end
                            end
                            CSUM: begin
                                if (word_done) begin
                                    if (word == checksum) begin
                                        bus.done <= 1'b1;
                                    end else begin
                                        bus.err <= 1'b1;
                                    end
                                    state <= DONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
